// File: rtl/enemy_ai.sv
// Per-enemy tank controller: wanders with an LFSR, chases the player on some turns,
// backs off from obstacles and fires periodically or when lined up with the target.
module enemy_ai #(
    parameter logic [15:0] SEED         = 16'hACE1,
    parameter logic [3:0]  SPAWN_DIR    = 4'b0010,
    parameter logic [7:0]  SPAWN_DELAY  = 8'd30,
    parameter logic [7:0]  MIN_RUN      = 8'd32,
    parameter logic [7:0]  PAUSE_FRAMES = 8'd8,
    parameter logic [7:0]  FIRE_PERIOD  = 8'd90,
    parameter logic [9:0]  ALIGN_TOL    = 10'd8
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       enable,
    input  logic       blocked,
    input  logic [9:0] TankX,
    input  logic [9:0] TankY,
    input  logic [9:0] target_x,
    input  logic [9:0] target_y,
    input  logic       bullet_active,
    output logic       move_up,
    output logic       move_down,
    output logic       move_left,
    output logic       move_right,
    output logic       fire,
    output logic [1:0] ai_state
);
    typedef enum logic [1:0] {
        SPAWN_WAIT = 2'd0,
        CRUISE     = 2'd1,
        PAUSE      = 2'd2,
        TURN       = 2'd3
    } state_t;

    localparam logic [15:0] SEED_EFF    = (SEED == 16'h0000) ? 16'hACE1 : SEED;
    localparam logic [7:0]  HALF_PERIOD = FIRE_PERIOD >> 1;
    localparam logic [3:0]  DIR_UP      = 4'b0001;
    localparam logic [3:0]  DIR_DOWN    = 4'b0010;
    localparam logic [3:0]  DIR_LEFT    = 4'b0100;
    localparam logic [3:0]  DIR_RIGHT   = 4'b1000;

    state_t      state, state_n;
    logic [3:0]  dir, dir_n, cand, pick;
    logic        excl, excl_n, fire_n, aligned;
    logic [7:0]  spawn_cnt, spawn_n, run_cnt, run_n, pause_cnt, pause_n;
    logic [7:0]  fire_cnt, fire_cnt_n, run_load;
    logic [15:0] lfsr, lfsr_n;
    logic signed [10:0] dx, dy, ndx, ndy;
    logic [9:0]  adx, ady;

    assign lfsr_n   = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
    assign run_load = MIN_RUN + {2'b00, lfsr[5:0]};

    // Target offset relative to our tank; positive dx = target to the right, positive dy = below.
    assign dx  = $signed({1'b0, target_x}) - $signed({1'b0, TankX});
    assign dy  = $signed({1'b0, target_y}) - $signed({1'b0, TankY});
    assign ndx = -dx;
    assign ndy = -dy;
    assign adx = dx[10] ? ndx[9:0] : dx[9:0];
    assign ady = dy[10] ? ndy[9:0] : dy[9:0];

    always_comb begin
        aligned = 1'b0;
        case (dir)
            DIR_UP:    aligned = dy[10] && (adx <= ALIGN_TOL);
            DIR_DOWN:  aligned = !dy[10] && (dy != 11'sd0) && (adx <= ALIGN_TOL);
            DIR_LEFT:  aligned = dx[10] && (ady <= ALIGN_TOL);
            DIR_RIGHT: aligned = !dx[10] && (dx != 11'sd0) && (ady <= ALIGN_TOL);
            default:   aligned = 1'b0;
        endcase
    end

    // Turn decision: chase picks the dominant axis, otherwise lfsr[1:0] walks clockwise from up.
    always_comb begin
        cand = DIR_UP;
        if (lfsr[2]) begin
            if (adx >= ady) cand = dx[10] ? DIR_LEFT : DIR_RIGHT;
            else            cand = dy[10] ? DIR_UP : DIR_DOWN;
        end else begin
            case (lfsr[1:0])
                2'd0:    cand = DIR_UP;
                2'd1:    cand = DIR_RIGHT;
                2'd2:    cand = DIR_DOWN;
                default: cand = DIR_LEFT;
            endcase
        end
        pick = cand;
        if (excl && (cand == dir)) begin
            case (cand)
                DIR_UP:    pick = DIR_RIGHT;
                DIR_RIGHT: pick = DIR_DOWN;
                DIR_DOWN:  pick = DIR_LEFT;
                default:   pick = DIR_UP;
            endcase
        end
    end

    always_comb begin
        state_n    = state;
        dir_n      = dir;
        excl_n     = excl;
        spawn_n    = spawn_cnt;
        run_n      = run_cnt;
        pause_n    = pause_cnt;
        fire_cnt_n = fire_cnt;
        fire_n     = 1'b0;

        if (state == CRUISE) begin
            if (!bullet_active && !fire &&
                ((fire_cnt == 8'd0) || (aligned && (fire_cnt < HALF_PERIOD)))) begin
                fire_n     = 1'b1;
                fire_cnt_n = FIRE_PERIOD;
            end else if (fire_cnt != 8'd0) begin
                fire_cnt_n = fire_cnt - 8'd1;
            end
        end

        case (state)
            SPAWN_WAIT: begin
                if (spawn_cnt == 8'd0) begin
                    dir_n   = SPAWN_DIR;
                    run_n   = run_load;
                    state_n = CRUISE;
                end else begin
                    spawn_n = spawn_cnt - 8'd1;
                end
            end
            CRUISE: begin
                if (run_cnt != 8'd0) run_n = run_cnt - 8'd1;
                if (blocked) begin
                    pause_n = PAUSE_FRAMES;
                    excl_n  = 1'b1;
                    state_n = PAUSE;
                end else if (run_cnt == 8'd0) begin
                    excl_n  = 1'b0;
                    state_n = TURN;
                end
            end
            PAUSE: begin
                if (pause_cnt == 8'd0) state_n = TURN;
                else                   pause_n = pause_cnt - 8'd1;
            end
            default: begin
                dir_n   = pick;
                run_n   = run_load;
                state_n = CRUISE;
            end
        endcase

        // A dead tank restarts its spawn countdown and drops any pending turn.
        if (!enable) begin
            state_n    = SPAWN_WAIT;
            spawn_n    = SPAWN_DELAY;
            fire_cnt_n = FIRE_PERIOD;
            fire_n     = 1'b0;
        end
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state     <= SPAWN_WAIT;
            dir       <= SPAWN_DIR;
            excl      <= 1'b0;
            spawn_cnt <= SPAWN_DELAY;
            fire_cnt  <= FIRE_PERIOD;
            run_cnt   <= 8'd0;
            pause_cnt <= 8'd0;
            lfsr      <= SEED_EFF;
            fire      <= 1'b0;
        end else begin
            state     <= state_n;
            dir       <= dir_n;
            excl      <= excl_n;
            spawn_cnt <= spawn_n;
            fire_cnt  <= fire_cnt_n;
            run_cnt   <= run_n;
            pause_cnt <= pause_n;
            lfsr      <= lfsr_n;
            fire      <= fire_n;
        end
    end

    assign move_up    = dir[0] && (state == CRUISE);
    assign move_down  = dir[1] && (state == CRUISE);
    assign move_left  = dir[2] && (state == CRUISE);
    assign move_right = dir[3] && (state == CRUISE);
    assign ai_state   = state;
endmodule

// File: tb/tb_enemy_ai.sv
// Randomized bench for enemy_ai: a frame-level behavioural model predicts every frame's
// outputs into a queue, and a monitor compares them one edge later.
module tb_enemy_ai;
    localparam int N_CYCLES   = 6000;
    localparam int SPAWN_DLY  = 30;
    localparam int MIN_RUN    = 32;
    localparam int PAUSE_FR   = 8;
    localparam int FIRE_PER   = 90;
    localparam int ALIGN_TOL  = 8;

    logic       frame_clk, Reset, enable, blocked, bullet_active;
    logic [9:0] TankX, TankY, target_x, target_y;
    logic       move_up, move_down, move_left, move_right, fire;
    logic [1:0] ai_state;

    enemy_ai #(.SEED(16'h0000)) dut (
        .frame_clk(frame_clk), .Reset(Reset), .enable(enable), .blocked(blocked),
        .TankX(TankX), .TankY(TankY), .target_x(target_x), .target_y(target_y),
        .bullet_active(bullet_active),
        .move_up(move_up), .move_down(move_down), .move_left(move_left),
        .move_right(move_right), .fire(fire), .ai_state(ai_state)
    );

    initial frame_clk = 1'b1;
    always #5 frame_clk = ~frame_clk;

    // Expected word: {state[1:0], fire, right, left, down, up}
    logic [6:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    // Model: phase 0 spawn, 1 cruise, 2 pause, 3 turn; heading as compass 0 up, 1 right, 2 down, 3 left.
    int          m_phase, m_dir, m_spawn, m_run, m_pause, m_fire_t;
    bit          m_excl, m_fire;
    logic [15:0] m_lfsr;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_step(input bit rst, input bit en, input bit blk, input bit ba,
                              input int tx, input int ty, input int gx, input int gy);
        int dx, dy, cand;
        bit lined_up, shoot;
        logic [15:0] r;
        if (rst) begin
            m_phase = 0; m_dir = 2; m_excl = 0; m_spawn = SPAWN_DLY; m_fire_t = FIRE_PER;
            m_run = 0; m_pause = 0; m_lfsr = 16'hACE1; m_fire = 0;
            return;
        end
        r  = m_lfsr;
        dx = gx - tx;
        dy = gy - ty;
        case (m_dir)
            0:       lined_up = (dy < 0) && (iabs(dx) <= ALIGN_TOL);
            1:       lined_up = (dx > 0) && (iabs(dy) <= ALIGN_TOL);
            2:       lined_up = (dy > 0) && (iabs(dx) <= ALIGN_TOL);
            default: lined_up = (dx < 0) && (iabs(dy) <= ALIGN_TOL);
        endcase
        shoot = (m_phase == 1) && !ba && !m_fire &&
                ((m_fire_t == 0) || (lined_up && (m_fire_t < FIRE_PER / 2)));
        if (shoot) m_fire_t = FIRE_PER;
        else if ((m_phase == 1) && (m_fire_t > 0)) m_fire_t = m_fire_t - 1;
        m_fire = shoot;
        case (m_phase)
            0: begin
                if (m_spawn == 0) begin
                    m_dir = 2; m_run = MIN_RUN + int'(r[5:0]); m_phase = 1;
                end else m_spawn = m_spawn - 1;
            end
            1: begin
                if (blk) begin
                    m_pause = PAUSE_FR; m_excl = 1; m_phase = 2;
                end else if (m_run == 0) begin
                    m_excl = 0; m_phase = 3;
                end else m_run = m_run - 1;
            end
            2: begin
                if (m_pause == 0) m_phase = 3;
                else m_pause = m_pause - 1;
            end
            default: begin
                if (r[2]) begin
                    if (iabs(dx) >= iabs(dy)) cand = (dx >= 0) ? 1 : 3;
                    else                      cand = (dy >= 0) ? 2 : 0;
                end else cand = int'(r[1:0]);
                if (m_excl && (cand == m_dir)) cand = (cand + 1) % 4;
                m_dir = cand; m_run = MIN_RUN + int'(r[5:0]); m_phase = 1;
            end
        endcase
        if (!en) begin
            m_phase = 0; m_spawn = SPAWN_DLY; m_fire_t = FIRE_PER; m_fire = 0;
        end
        m_lfsr = r[0] ? ((r >> 1) ^ 16'hB400) : (r >> 1);
    endtask

    function automatic logic [6:0] model_expect();
        logic [3:0] mv;
        mv = 4'b0000;
        if (m_phase == 1) begin
            case (m_dir)
                0:       mv = 4'b0001;
                1:       mv = 4'b1000;
                2:       mv = 4'b0010;
                default: mv = 4'b0100;
            endcase
        end
        return {2'(m_phase), m_fire, mv};
    endfunction

    // Monitor: one expected word per frame edge.
    initial begin
        logic [6:0] e;
        logic [3:0] got_mv;
        int cyc;
        cyc = 0;
        forever begin
            @(posedge frame_clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got_mv = {move_right, move_left, move_down, move_up};
                checks++;
                if (ai_state !== e[6:5]) begin
                    errors++;
                    $display("FAIL state frame %0d: got %0d expected %0d", cyc, ai_state, e[6:5]);
                end
                checks++;
                if (fire !== e[4]) begin
                    errors++;
                    $display("FAIL fire frame %0d: got %0b expected %0b", cyc, fire, e[4]);
                end
                checks++;
                if (got_mv !== e[3:0]) begin
                    errors++;
                    $display("FAIL move frame %0d: got rldu=%b expected rldu=%b", cyc, got_mv, e[3:0]);
                end
                cyc++;
            end
        end
    end

    // Driver: inputs change on the falling edge; the model predicts the next rising edge.
    initial begin
        int tx, ty, gx, gy, mode, axis, side, along, off, d;
        int en_low, ba_left;
        bit rst, en, blk, ba;
        Reset = 1'b1; enable = 1'b1; blocked = 1'b0; bullet_active = 1'b0;
        TankX = 10'd400; TankY = 10'd400; target_x = 10'd0; target_y = 10'd0;
        tx = 400; ty = 400; mode = 0; axis = 0; side = 1; along = 100;
        en_low = 0; ba_left = 0;
        for (int c = 0; c < N_CYCLES; c++) begin
            @(negedge frame_clk);
            rst = (c < 3) || ((c >= 3500) && (c < 3503));
            if (c % 64 == 0) begin
                tx    = 300 + $urandom_range(0, 400);
                ty    = 300 + $urandom_range(0, 400);
                mode  = $urandom_range(0, 2);
                axis  = $urandom_range(0, 1);
                side  = ($urandom_range(0, 1) == 1) ? 1 : -1;
                along = side * $urandom_range(50, 200);
            end
            case (mode)
                0: begin
                    gx = $urandom_range(0, 1023);
                    gy = $urandom_range(0, 1023);
                end
                1: begin
                    off = $urandom_range(0, 24) - 12;
                    if (axis == 0) begin gx = tx + off;   gy = ty + along; end
                    else           begin gx = tx + along; gy = ty + off;   end
                end
                default: begin
                    d  = $urandom_range(0, 60);
                    gx = ($urandom_range(0, 1) == 1) ? tx + d : tx - d;
                    gy = ($urandom_range(0, 1) == 1) ? ty + d : ty - d;
                end
            endcase
            if ((c >= 1500) && (c < 2500)) blk = ($urandom_range(0, 5) == 0);
            else                           blk = ($urandom_range(0, 39) == 0);
            if (en_low > 0) begin
                en = 0; en_low--;
            end else begin
                en = 1;
                if ((c > 600) && ($urandom_range(0, 399) == 0)) en_low = $urandom_range(1, 6);
            end
            if (ba_left > 0) begin
                ba = 1; ba_left--;
            end else begin
                ba = 0;
                if ($urandom_range(0, 149) == 0) ba_left = $urandom_range(5, 120);
            end
            Reset = rst; enable = en; blocked = blk; bullet_active = ba;
            TankX = 10'(tx); TankY = 10'(ty); target_x = 10'(gx); target_y = 10'(gy);
            model_step(rst, en, blk, ba, tx, ty, gx, gy);
            exp_q.push_back(model_expect());
        end
        for (int k = 0; (k < 4) && (exp_q.size() > 0); k++) @(posedge frame_clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected frames left unchecked, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/enemy_ai.md
# enemy_ai

Per-enemy movement and fire controller. Drives the `move_up`, `move_down`, `move_left`, `move_right` and `fire` inputs of one enemy tank instance, and consumes that tank's `blocked`, `TankX`/`TankY` and `bullet_active` outputs. The top level instantiates one `enemy_ai` per enemy tank. Each instance is given a distinct `SEED` so that the enemies wander independently and drift toward the player.

## Interface
- `SEED`, 16'hACE1: LFSR seed. A value of 0 is replaced by 16'hACE1.
- `SPAWN_DIR`, 4'b0010: one-hot initial direction (bit0 up, bit1 down, bit2 left, bit3 right).
- `SPAWN_DELAY`, 8'd30: idle frames after reset, or after `enable` rises, before the first move.
- `MIN_RUN`, 8'd32: minimum frames per straight run. Must be ≤ 192.
- `PAUSE_FRAMES`, 8'd8: idle frames after hitting an obstacle.
- `FIRE_PERIOD`, 8'd90: frames between periodic shots.
- `ALIGN_TOL`, 10'd8: pixel tolerance for the aligned-shot test.
---
- `frame_clk`, in, 1: sole clock, one edge per video frame.
- `Reset`, in, 1: synchronous, active-high reset.
- `enable`, in, 1: low while the tank is dead or respawning. When low, the block is forced idle.
- `blocked`, in, 1: the tank's blocked flag for the current move request.
- `TankX`, `TankY`, in, 10 each: position of the controlled tank.
- `target_x`, `target_y`, in, 10 each: position of the player tank.
- `bullet_active`, in, 1: the controlled tank's own bullet is in flight.
- `move_up`, `move_down`, `move_left`, `move_right`, out, 1 each: move request. At most one is high.
- `fire`, out, 1: single-frame fire pulse.
- `ai_state`, out, 2: current state, for debug.

## Operation
- **LFSR.** 16-bit Galois LFSR, taps x^16+x^14+x^13+x^11 (mask 16'hB400). It advances on every `frame_clk` edge, independent of state. On reset it loads `SEED`, or 16'hACE1 if `SEED` is 0.
- **States.**
  - `SPAWN_WAIT` = 0
  - `CRUISE` = 1
  - `PAUSE` = 2
  - `TURN` = 3
- **Move outputs.** `move_*` are the `dir` register bits ANDed with (state == `CRUISE`). There is no combinational path from any input to any output.
- **`SPAWN_WAIT`.**
  - All outputs are 0 and `spawn_cnt` decrements.
  - When `spawn_cnt` is 0: `dir` ← `SPAWN_DIR`, `run_cnt` ← `MIN_RUN` + `lfsr[5:0]`, go to `CRUISE`.
- **`CRUISE`.** `run_cnt` decrements each frame. Priority order:
  1. `blocked` = 1: `pause_cnt` ← `PAUSE_FRAMES`, set `excl` = 1, go to `PAUSE`.
  2. Otherwise, `run_cnt` = 0: set `excl` = 0, go to `TURN`.
- **`PAUSE`.** Outputs are 0 and `pause_cnt` decrements. At 0, go to `TURN`.
- **`TURN`.** Lasts exactly one frame with outputs 0.
  - **Chase** (`lfsr[2]` = 1):
    - If |`target_x`−`TankX`| ≥ |`target_y`−`TankY`|, pick the horizontal direction toward the target.
    - Otherwise pick the vertical direction toward the target.
    - On equality of coordinates on the chosen axis, pick right (horizontal) or down (vertical).
  - **Random** (`lfsr[2]` = 0): `lfsr[1:0]` selects 0 = up, 1 = right, 2 = down, 3 = left.
  - **Exclusion.** If `excl` = 1 and the candidate equals the current `dir`, rotate clockwise: up→right→down→left→up.
  - **Exit.** `dir` ← result, `run_cnt` ← `MIN_RUN` + `lfsr[5:0]`, go to `CRUISE`.
  - **Arithmetic.** Differences use 11-bit signed arithmetic. Absolute values are 10-bit unsigned.
- **Fire.**
  - `fire_cnt` decrements each frame in `CRUISE`, saturating at 0.
  - **Aligned** means `dir` points toward the target and the perpendicular-axis distance is ≤ `ALIGN_TOL`.
  - **Pulse condition.** `fire` is registered. It pulses 1 for one frame when all of the following hold:
    - state is `CRUISE` and `bullet_active` = 0;
    - (`fire_cnt` = 0) OR (aligned AND `fire_cnt` < `FIRE_PERIOD`/2).
  - **Reload.** On every pulse, `fire_cnt` ← `FIRE_PERIOD`.
  - `fire` is never high for two consecutive frames.
- **`enable` low.**
  - In any state, on the next edge: state ← `SPAWN_WAIT`, `spawn_cnt` ← `SPAWN_DELAY`, `fire_cnt` ← `FIRE_PERIOD`, `fire` ← 0.
  - The block holds there while `enable` stays low.
- **Reset** (synchronous, highest priority):
  - state `SPAWN_WAIT`, `ai_state` = 0;
  - `dir` = `SPAWN_DIR`, `excl` = 0;
  - `spawn_cnt` = `SPAWN_DELAY`, `fire_cnt` = `FIRE_PERIOD`, `run_cnt` = 0, `pause_cnt` = 0;
  - `lfsr` = seed;
  - all `move_*` = 0, `fire` = 0.
- **Widths.** All counters are 8-bit unsigned.

## Timing
- **Outputs.** All outputs update only on `frame_clk` edges and are glitch-free for the tank's combinational logic.
- **Blocked response.** If `blocked` is high at edge N in `CRUISE`:
  - `move_*` are 0 from N+1;
  - `PAUSE` occupies `PAUSE_FRAMES`+1 frames;
  - `TURN` occupies 1 frame;
  - movement resumes in the new direction `PAUSE_FRAMES`+2 frames after N+1.
- **Run expiry.** Expiry produces exactly one idle frame (`TURN`).
- **Spawn latency.** The first move appears `SPAWN_DELAY`+1 edges after reset deassertion.
- **Same-edge conflicts.**
  - `blocked` and `run_cnt` = 0 on the same edge: the blocked path wins.
  - A fire condition and `blocked` on the same edge: `fire` still pulses.
- **`enable` drop.** Dropping `enable` mid-pause or mid-turn discards the pending turn.

## Test plan
- **Reset.** Hold `Reset` 3 frames, then release. Expect all outputs 0 and `ai_state` = 0. `move_down` = 1 first appears exactly 31 edges after release.
- **Blocked response.** In `CRUISE` with `dir` = down, assert `blocked` for one frame. Expect:
  - 10 frames of all `move_*` = 0 (`ai_state` 2 for 9 frames, then 3 for 1);
  - then exactly one `move_*` high, and it is not `move_down`.
- **Run expiry.** Force `run_cnt` expiry with `blocked` = 0. Expect exactly one idle frame, then `CRUISE` again. Over 1000 frames, `run_cnt` reloads are in [32, 95].
- **Periodic fire.** `bullet_active` held 0, target unaligned. Expect `fire` pulses every 91 frames in `CRUISE`. With `bullet_active` = 1, expect no pulses. On release, a pulse follows on the next edge.
- **Aligned fire.** Target 100 px directly ahead, perpendicular offset 5. With `fire_cnt` at 40, expect `fire` = 1 on the next edge. With offset 9, expect no pulse.
- **Enable drop.** Drop `enable` mid-`CRUISE` for 5 frames. Expect `move_*`/`fire` 0 on the next edge, `ai_state` = 0, and movement resuming 31 edges after `enable` rises.
